// File: rtl/htif_arbiter.sv
// Round-robin arbiter/sequencer for the tohost write channel: serialises requester words,
// strobes tohost_we once per word, latches exit words and forwards console characters.
// Optional console timeout is built when HTIF_CONS_TIMEOUT_EN is defined.
module htif_arbiter #(
   parameter int NREQ  = 2,
   parameter int TMO_W = 8
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*32-1:0]  req_data,
   output logic [NREQ-1:0]     req_ready,
   output logic                tohost_we,
   output logic [31:0]         tohost,
   output logic [2:0]          tohost_src,
   output logic                cons_valid,
   output logic [7:0]          cons_data,
   input  logic                cons_ready,
   output logic                halted,
   output logic [31:0]         exit_code,
   output logic                cons_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, CONS, HALT} state_t;

   state_t      state_reg, state_next;
   logic [2:0]  ptr_reg, ptr_next;
   logic [31:0] tohost_reg;
   logic [2:0]  src_reg;
   logic        halted_reg;
   logic [31:0] exit_code_reg;
   logic        cons_err_reg;
   logic        tmo_fire;

   logic [7:0]  valid_ext;
   logic [31:0] word_arr [8];
   logic [3:0]  rot_idx;
   logic [2:0]  grant_idx;
   logic        grant_found;
   logic        accept;

   // Requesters are padded to eight lanes so the rotation can index with a fixed 3-bit value.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         if (gi < NREQ) begin : g_used
            assign valid_ext[gi] = req_valid[gi];
            assign word_arr[gi]  = req_data[32*gi +: 32];
            assign req_ready[gi] = accept && (grant_idx == 3'(gi));
         end else begin : g_pad
            assign valid_ext[gi] = 1'b0;
            assign word_arr[gi]  = '0;
         end
      end
   endgenerate

   // First valid requester scanning ptr, ptr+1, ... modulo NREQ.
   always_comb begin
      grant_idx   = '0;
      grant_found = 1'b0;
      rot_idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         rot_idx = {1'b0, ptr_reg} + 4'(k);
         if (rot_idx >= 4'(NREQ))
            rot_idx = rot_idx - 4'(NREQ);
         if (!grant_found && valid_ext[rot_idx[2:0]]) begin
            grant_found = 1'b1;
            grant_idx   = rot_idx[2:0];
         end
      end
   end

   assign accept = (state_reg == IDLE) && grant_found;

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = ISSUE;
               ptr_next   = (grant_idx == 3'(NREQ-1)) ? 3'd0 : grant_idx + 3'd1;
            end
         end
         ISSUE: begin
            state_next = tohost_reg[0] ? HALT : CONS;
         end
         CONS: begin
            if (cons_ready || tmo_fire)
               state_next = IDLE;
         end
         HALT: begin
            state_next = HALT;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tohost_reg    <= '0;
         src_reg       <= '0;
         halted_reg    <= 1'b0;
         exit_code_reg <= '0;
      end else begin
         if (accept) begin
            tohost_reg <= word_arr[grant_idx];
            src_reg    <= grant_idx;
         end
         if (state_reg == ISSUE && tohost_reg[0]) begin
            halted_reg    <= 1'b1;
            exit_code_reg <= tohost_reg;
         end
      end
   end

`ifdef HTIF_CONS_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt_reg;

   // Fire on the stalled cycle that would bring the counter to all-ones.
   assign tmo_fire = (state_reg == CONS) && !cons_ready &&
                     ((tmo_cnt_reg + TMO_W'(1)) == {TMO_W{1'b1}});

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tmo_cnt_reg  <= '0;
         cons_err_reg <= 1'b0;
      end else begin
         if (state_reg == ISSUE)
            tmo_cnt_reg <= '0;
         else if (state_reg == CONS && !cons_ready)
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
         if (tmo_fire)
            cons_err_reg <= 1'b1;
      end
   end
`else
   assign tmo_fire     = 1'b0;
   assign cons_err_reg = 1'b0;
`endif

   assign tohost_we  = (state_reg == ISSUE);
   assign tohost     = tohost_reg;
   assign tohost_src = src_reg;
   assign cons_valid = (state_reg == CONS);
   assign cons_data  = tohost_reg[15:8];
   assign halted     = halted_reg;
   assign exit_code  = exit_code_reg;
   assign cons_err   = cons_err_reg;

endmodule

// File: tb/tb_htif_arbiter.sv
// Scoreboard bench for htif_arbiter: a batch-level round-robin model predicts the order of
// tohost writes and console characters; a negedge monitor pops and compares them.
module tb_htif_arbiter;
   localparam int NREQ  = 2;
   localparam int TMO_W = 4;

   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ*32-1:0] req_data  = '0;
   logic [NREQ-1:0]    req_ready;
   logic               tohost_we;
   logic [31:0]        tohost;
   logic [2:0]         tohost_src;
   logic               cons_valid;
   logic [7:0]         cons_data;
   logic               cons_ready = 1'b1;
   logic               halted;
   logic [31:0]        exit_code;
   logic               cons_err;

   htif_arbiter #(.NREQ(NREQ), .TMO_W(TMO_W)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .tohost_we(tohost_we), .tohost(tohost), .tohost_src(tohost_src),
      .cons_valid(cons_valid), .cons_data(cons_data), .cons_ready(cons_ready),
      .halted(halted), .exit_code(exit_code), .cons_err(cons_err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          src;
      logic [31:0] word;
   } iss_t;

   iss_t        q_iss[$];
   logic [7:0]  q_cons[$];
   logic [31:0] batch_words [NREQ];
   int          model_ptr = 0;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          last_acc_cyc = -10;
   int          we_count = 0;
   int          cons_cycles = 0;
   bit          rand_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: compares every tohost write and console handshake against the queues.
   always @(negedge CLK) begin
      if (!RST) begin
         if ((req_valid & req_ready) != '0)
            last_acc_cyc = cyc;
         check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
         if (cons_valid)
            cons_cycles++;
         if (tohost_we) begin
            we_count++;
            if (q_iss.size() == 0) begin
               fail_now("unexpected_tohost_we");
            end else begin
               iss_t e;
               e = q_iss.pop_front();
               check("tohost", tohost, e.word);
               check("tohost_src", 32'(tohost_src), 32'(e.src));
               check("we_latency", 32'(cyc - last_acc_cyc), 32'd1);
               if (!e.word[0])
                  q_cons.push_back(e.word[15:8]);
               $display("txn src=%0d word=%h", tohost_src, tohost);
            end
         end
         if (cons_valid && cons_ready) begin
            if (q_cons.size() == 0)
               fail_now("unexpected_cons");
            else
               check("cons_data", 32'(cons_data), 32'(q_cons.pop_front()));
         end
      end
   end

   // Reference: with every batch member held, service order is repeated round-robin from model_ptr.
   task automatic model_push(input logic [NREQ-1:0] mask);
      logic [NREQ-1:0] pend;
      iss_t e;
      int i;
      pend = mask;
      while (pend != '0) begin
         for (int k = 0; k < NREQ; k++) begin
            i = (model_ptr + k) % NREQ;
            if (pend[i]) begin
               e.src  = i;
               e.word = batch_words[i];
               q_iss.push_back(e);
               pend[i]   = 1'b0;
               model_ptr = (i + 1) % NREQ;
               break;
            end
         end
      end
   endtask

   task automatic next_ready();
      cons_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic run_batch(input logic [NREQ-1:0] mask);
      logic [NREQ-1:0] acc;
      int guard;
      model_push(mask);
      @(posedge CLK); #1;
      for (int i = 0; i < NREQ; i++)
         req_data[i*32 +: 32] = batch_words[i];
      req_valid = mask;
      guard = 0;
      while (req_valid != '0 && guard < 100) begin
         @(negedge CLK);
         acc = req_valid & req_ready;
         @(posedge CLK); #1;
         req_valid = req_valid & ~acc;
         next_ready();
         guard++;
      end
      if (req_valid != '0) fail_now("batch_accept");
      req_valid = '0;
      guard = 0;
      while ((q_iss.size() != 0 || q_cons.size() != 0) && guard < 200) begin
         @(posedge CLK); #1;
         next_ready();
         guard++;
      end
      if (q_iss.size() != 0 || q_cons.size() != 0) fail_now("batch_drain");
   endtask

   task automatic do_reset();
      @(posedge CLK); #1;
      RST = 1'b1;
      req_valid = '0;
      q_iss.delete();
      q_cons.delete();
      model_ptr = 0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   // Posts one word from requester 0 with cons_ready low, returns once cons_valid is seen.
   task automatic post_stalled(input logic [31:0] w);
      int g;
      cons_ready = 1'b0;
      batch_words[0] = w;
      model_push(2'b01);
      @(posedge CLK); #1;
      req_data[31:0] = w;
      req_valid = 2'b01;
      g = 0;
      @(negedge CLK);
      while (!req_ready[0] && g < 10) begin
         @(negedge CLK);
         g++;
      end
      @(posedge CLK); #1;
      req_valid = '0;
      g = 0;
      @(negedge CLK);
      while (!cons_valid && g < 10) begin
         @(negedge CLK);
         g++;
      end
      if (!cons_valid) fail_now("stall_cons_valid");
   endtask

   initial begin
      int n;
      int c0;
      int w0;
      bit seen_ready;

      // Reset values while RST is held.
      repeat (2) @(negedge CLK);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_tohost_we", 32'(tohost_we), 32'd0);
      check("rst_tohost", tohost, 32'd0);
      check("rst_tohost_src", 32'(tohost_src), 32'd0);
      check("rst_cons_valid", 32'(cons_valid), 32'd0);
      check("rst_cons_data", 32'(cons_data), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_exit_code", exit_code, 32'd0);
      check("rst_cons_err", 32'(cons_err), 32'd0);
      @(posedge CLK); #1 RST = 1'b0;
      repeat (3) @(negedge CLK);
      check("idle_no_ready", 32'(req_ready), 32'd0);

      // Single console word with cons_ready high: CONS lasts one cycle.
      rand_ready = 1'b0;
      batch_words[0] = 32'h0000_4100;
      batch_words[1] = 32'h0000_0000;
      c0 = cons_cycles;
      run_batch(2'b01);
      check("cons_one_cycle", 32'(cons_cycles - c0), 32'd1);

      // Both requesters held: alternating grants.
      for (int t = 0; t < 2; t++) begin
         batch_words[0] = 32'h0000_3000 + 32'(t) * 32'h200;
         batch_words[1] = 32'h0000_3100 + 32'(t) * 32'h200;
         run_batch(2'b11);
      end

      // Randomised batches with random console back-pressure.
      rand_ready = 1'b1;
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < NREQ; i++)
            batch_words[i] = $urandom & 32'hFFFF_FFFE;
         run_batch(NREQ'($urandom_range(1, 3)));
      end
      rand_ready = 1'b0;

      // Exit word from requester 1, then requester 0 must never be granted.
      batch_words[1] = 32'h0000_0001;
      run_batch(2'b10);
      check("halted_set", 32'(halted), 32'd1);
      check("exit_code_1", exit_code, 32'h1);
      req_data[31:0] = 32'h0000_4200;
      req_valid = 2'b01;
      seen_ready = 1'b0;
      repeat (10) begin
         @(negedge CLK);
         if (req_ready != '0) seen_ready = 1'b1;
      end
      check("halt_no_ready", 32'(seen_ready), 32'd0);
      check("halt_sticky", 32'(halted), 32'd1);
      req_valid = '0;

      // Exit code 7: exactly one write strobe.
      do_reset();
      w0 = we_count;
      batch_words[0] = 32'h0000_0007;
      run_batch(2'b01);
      repeat (5) @(negedge CLK);
      check("exit_code_7", exit_code, 32'h7);
      check("exit_we_once", 32'(we_count - w0), 32'd1);

      // Console stall.
      do_reset();
      post_stalled(32'h0000_5A00);
      n = 0;
`ifdef HTIF_CONS_TIMEOUT_EN
      while (cons_valid && n < 30) begin
         n++;
         @(negedge CLK);
      end
      check("tmo_valid_cycles", 32'(n), 32'd15);
      check("tmo_cons_err", 32'(cons_err), 32'd1);
      if (q_cons.size() != 0) void'(q_cons.pop_front());
      cons_ready = 1'b1;
`else
      while (cons_valid && n < 20) begin
         n++;
         @(negedge CLK);
      end
      check("stall_valid_cycles", 32'(n), 32'd20);
      check("stall_cons_err", 32'(cons_err), 32'd0);
      @(posedge CLK); #1 cons_ready = 1'b1;
      n = 0;
      while (q_cons.size() != 0 && n < 10) begin
         @(posedge CLK);
         n++;
      end
      if (q_cons.size() != 0) fail_now("stall_release");
`endif
      repeat (2) @(posedge CLK);

      // RST during CONS: outputs return to reset values at once; pointer restarts at 0.
      post_stalled(32'h0000_6600);
      #2 RST = 1'b1;
      #1;
      check("midrst_req_ready", 32'(req_ready), 32'd0);
      check("midrst_tohost_we", 32'(tohost_we), 32'd0);
      check("midrst_tohost", tohost, 32'd0);
      check("midrst_tohost_src", 32'(tohost_src), 32'd0);
      check("midrst_cons_valid", 32'(cons_valid), 32'd0);
      check("midrst_cons_data", 32'(cons_data), 32'd0);
      check("midrst_halted", 32'(halted), 32'd0);
      check("midrst_exit_code", exit_code, 32'd0);
      check("midrst_cons_err", 32'(cons_err), 32'd0);
      q_iss.delete();
      q_cons.delete();
      model_ptr = 0;
      cons_ready = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      batch_words[0] = 32'h0000_7000;
      batch_words[1] = 32'h0000_7100;
      run_batch(2'b11);

      repeat (3) @(negedge CLK);
      check("final_q_iss_empty", 32'(q_iss.size()), 32'd0);
      check("final_q_cons_empty", 32'(q_cons.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "global timeout");
   end
endmodule

// File: doc/htif_arbiter.md
# htif_arbiter

Round-robin arbiter and sequencer for the 32-bit host-target (tohost) write channel consumed by the simulation testbench. Up to NREQ requesters (harts or debug agents) post tohost words. The block serialises them, drives one single-cycle `tohost_we` pulse per word, and decodes each word:

- exit word: bit 0 set; latched and sticky-halts the channel.
- console word: bit 0 clear; forwarded through a ready/valid console port.

It sits between the core-side store logic and the testbench exit/console monitor.

## Interface
- NREQ, 2: number of requesters; 1..8.
- TMO_W, 8: console-timeout counter width. Timeout fires after 2^TMO_W−1 stalled cycles.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- req_valid  in  NREQ  per-requester word valid.
- req_data  in  NREQ×32  packed words; requester i occupies bits [32i+31:32i].
- req_ready  out  NREQ  one-hot accept; at most one bit set per cycle.
- tohost_we  out  1  single-cycle write strobe toward the host monitor.
- tohost  out  32  word being written; valid while `tohost_we`=1.
- tohost_src  out  3  index of the requester that owns the current word.
- cons_valid  out  1  console character valid.
- cons_data  out  8  console character (bits [15:8] of the console word).
- cons_ready  in  1  console sink accepts.
- halted  out  1  sticky; set by an exit word.
- exit_code  out  32  exit word as written; held while `halted`=1.
- cons_err  out  1  sticky; a console character was dropped on timeout.

## Operation
- State machine states: IDLE, ISSUE, CONS, HALT.
- IDLE:
  - `req_ready[g]`=1 only for the granted index g, computed combinationally.
  - Arbitration is round-robin starting at `ptr`: g is the first i in ptr, ptr+1, …, ptr+NREQ−1 (mod NREQ) with `req_valid[i]`=1.
  - On `req_valid[g]&&req_ready[g]`: latch the word into `tohost`, latch g into `tohost_src`, set ptr=(g+1) mod NREQ, go to ISSUE.
  - With no valid requester: `req_ready`=0 and ptr is unchanged.
- ISSUE:
  - `tohost_we`=1 for exactly this cycle.
  - If word[0]=1: set `halted`, load `exit_code`, go to HALT.
  - Else: go to CONS.
- CONS:
  - `cons_valid`=1 and `cons_data`=word[15:8].
  - On `cons_ready`=1: go to IDLE.
  - Other word bits are ignored.
- HALT:
  - Terminal; `req_ready`=0 permanently.
  - Leaving HALT requires RST.
- `req_ready` is 0 in every state other than IDLE.
- Requesters must hold `req_valid` and `req_data` stable until accepted.
- A word with value 32'h0 is a console word carrying character 0; it is not special.

## Timing
- Reset values:
  - state=IDLE, ptr=0.
  - `req_ready`=0 until the first cycle after RST deassertion in which a requester is valid.
  - `tohost_we`=0, `tohost`=0, `tohost_src`=0.
  - `cons_valid`=0, `cons_data`=0.
  - `halted`=0, `exit_code`=0, `cons_err`=0.
- Latency: word accepted in cycle T → `tohost_we` in T+1 → `cons_valid` from T+2 (console word) or `halted`=1 in T+2 (exit word).
- Minimum spacing between accepts is 3 cycles (console word with `cons_ready` already high).
- Simultaneous requests: exactly one is granted per accept. After grant g, the next priority starts at g+1, so no requester is starved while it holds `req_valid`.
- RST asserted mid-operation: all state returns to reset values immediately and asynchronously. A word in flight is discarded, with no `tohost_we` and no console output.
- `cons_ready` already high on CONS entry: CONS lasts exactly 1 cycle.

## Configuration
- HTIF_CONS_TIMEOUT_EN defined:
  - A TMO_W-bit counter clears on CONS entry and increments on each CONS cycle with `cons_ready`=0.
  - When the counter reaches all-ones: drop the character, set `cons_err`, return to IDLE the next cycle.
- HTIF_CONS_TIMEOUT_EN undefined:
  - No counter is built; CONS waits indefinitely.
  - `cons_err` is tied to 0.

## Test plan
- Reset, then requester 0 posts 32'h0000_4100 with `cons_ready`=1 → `tohost_we` pulse with `tohost`=32'h0000_4100 and `tohost_src`=0 one cycle after accept; one `cons_valid` cycle with `cons_data`=8'h41; return to IDLE.
- Both requesters hold console words for 4 transactions (NREQ=2) → grants alternate 0,1,0,1 and `tohost_src` matches each grant.
- Requester 1 posts 32'h0000_0001 → `halted`=1 and `exit_code`=32'h1. A subsequent request from requester 0 never sees `req_ready`.
- Exit word 32'h0000_0007 (test 3 fails) → `exit_code`=32'h7; `tohost_we` pulses exactly once.
- Console word with `cons_ready`=0 (HTIF_CONS_TIMEOUT_EN, TMO_W=4) → `cons_valid` held 15 cycles, then `cons_err`=1 and return to IDLE. Without the macro, `cons_valid` holds until `cons_ready` rises.
- RST asserted during CONS → all outputs at reset values in the same cycle. After release, a fresh request is granted starting from requester 0.
